// File: rtl/mac_checker.sv
// Receive-side lane-stream frame checker: delineates frames, captures header/FCS, classifies good/bad.
// One clock from terminate/abort word to completion pulse; no backpressure, input accepted every cycle.
module mac_checker #(
  parameter int         DATA_WIDTH      = 64,
  parameter int         CTRL_WIDTH      = DATA_WIDTH / 8,
  parameter int         MIN_FRAME_BYTES = 64,
  parameter int         MAX_FRAME_BYTES = 1518,
  parameter logic [7:0] START_CODE      = 8'hFB,
  parameter logic [7:0] TERMINATE_CODE  = 8'hFD,
  parameter logic [7:0] PREAMBLE_CODE   = 8'h55,
  parameter logic [7:0] SFD_CODE        = 8'hD5
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic [CTRL_WIDTH-1:0] i_rx_ctrl,
  output logic                  o_frame_valid,
  output logic                  o_frame_error,
  output logic [3:0]            o_err_flags,
  output logic [47:0]           o_dst_addr,
  output logic [47:0]           o_src_addr,
  output logic [15:0]           o_len_type,
  output logic [31:0]           o_fcs,
  output logic [15:0]           o_frame_bytes,
  output logic [15:0]           o_payload_bytes,
  output logic [15:0]           o_good_cnt,
  output logic [15:0]           o_bad_cnt
);

  localparam logic [15:0] CNT_SAT = 16'(MAX_FRAME_BYTES + 8);
  localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME_BYTES);
  localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME_BYTES);

  typedef enum logic {IDLE, BODY} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [47:0] dst_q, dst_d;
  logic [47:0] src_q, src_d;
  logic [15:0] len_q, len_d;
  logic [31:0] fcs_q, fcs_d;
  logic        pre_err_q, pre_err_d;

  logic        frame_valid_q, frame_valid_d;
  logic        frame_error_q, frame_error_d;
  logic [3:0]  err_flags_q, err_flags_d;
  logic [47:0] dst_addr_q, dst_addr_d;
  logic [47:0] src_addr_q, src_addr_d;
  logic [15:0] len_type_q, len_type_d;
  logic [31:0] fcs_out_q, fcs_out_d;
  logic [15:0] frame_bytes_q, frame_bytes_d;
  logic [15:0] payload_bytes_q, payload_bytes_d;
  logic [15:0] good_cnt_q, good_cnt_d;
  logic [15:0] bad_cnt_q, bad_cnt_d;

  logic        is_start;
  logic        pre_bad;
  logic        has_ctl;
  logic        seen;
  logic [7:0]  ctl_code;
  logic [7:0]  lane_byte;
  logic [15:0] idx;
  logic [3:0]  flags_now;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    dst_d           = dst_q;
    src_d           = src_q;
    len_d           = len_q;
    fcs_d           = fcs_q;
    pre_err_d       = pre_err_q;
    frame_valid_d   = 1'b0;
    frame_error_d   = 1'b0;
    err_flags_d     = err_flags_q;
    dst_addr_d      = dst_addr_q;
    src_addr_d      = src_addr_q;
    len_type_d      = len_type_q;
    fcs_out_d       = fcs_out_q;
    frame_bytes_d   = frame_bytes_q;
    payload_bytes_d = payload_bytes_q;
    good_cnt_d      = good_cnt_q;
    bad_cnt_d       = bad_cnt_q;
    seen            = 1'b0;
    ctl_code        = 8'h00;
    lane_byte       = 8'h00;
    idx             = cnt_q;
    flags_now       = 4'b0000;
    has_ctl         = |i_rx_ctrl;

    is_start = (i_rx_ctrl == CTRL_WIDTH'(1)) && (i_rx_data[7:0] == START_CODE);
    pre_bad  = (i_rx_data[DATA_WIDTH-1 -: 8] != SFD_CODE);
    for (int j = 1; j < CTRL_WIDTH - 1; j++) begin
      if (i_rx_data[8*j +: 8] != PREAMBLE_CODE) pre_bad = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (is_start) begin
          state_d   = BODY;
          cnt_d     = '0;
          dst_d     = '0;
          src_d     = '0;
          len_d     = '0;
          fcs_d     = '0;
          pre_err_d = pre_bad;
        end
      end
      default: begin
        // Only lanes ahead of the first control character belong to the frame.
        for (int j = 0; j < CTRL_WIDTH; j++) begin
          lane_byte = i_rx_data[8*j +: 8];
          if (!seen && i_rx_ctrl[j]) ctl_code = lane_byte;
          seen = seen | i_rx_ctrl[j];
          if (!seen) begin
            for (int p = 0; p < 6; p++) begin
              if (idx == 16'(p))     dst_d[8*(5-p) +: 8] = lane_byte;
              if (idx == 16'(p + 6)) src_d[8*(5-p) +: 8] = lane_byte;
            end
            for (int p = 0; p < 2; p++) begin
              if (idx == 16'(p + 12)) len_d[8*(1-p) +: 8] = lane_byte;
            end
            fcs_d = {fcs_d[23:0], lane_byte};
            idx   = idx + 16'd1;
          end
        end
        cnt_d = (idx > CNT_SAT) ? CNT_SAT : idx;

        if (has_ctl) begin
          state_d = IDLE;
          // Length checks only make sense for a properly terminated frame.
          if (ctl_code == TERMINATE_CODE) begin
            flags_now = {1'b0, (cnt_d > MAX_LEN), (cnt_d < MIN_LEN), pre_err_q};
          end else begin
            flags_now = {1'b1, 2'b00, pre_err_q};
          end
          err_flags_d     = flags_now;
          dst_addr_d      = dst_d;
          src_addr_d      = src_d;
          len_type_d      = len_d;
          fcs_out_d       = fcs_d;
          frame_bytes_d   = cnt_d;
          payload_bytes_d = (cnt_d < 16'd18) ? 16'd0 : cnt_d - 16'd18;
          if (flags_now == 4'b0000) begin
            frame_valid_d = 1'b1;
            good_cnt_d    = good_cnt_q + 16'd1;
          end else begin
            frame_error_d = 1'b1;
            bad_cnt_d     = bad_cnt_q + 16'd1;
          end

          // A start word both aborts the current frame and opens the next one.
          if (is_start) begin
            state_d   = BODY;
            cnt_d     = '0;
            dst_d     = '0;
            src_d     = '0;
            len_d     = '0;
            fcs_d     = '0;
            pre_err_d = pre_bad;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      dst_q           <= '0;
      src_q           <= '0;
      len_q           <= '0;
      fcs_q           <= '0;
      pre_err_q       <= 1'b0;
      frame_valid_q   <= 1'b0;
      frame_error_q   <= 1'b0;
      err_flags_q     <= '0;
      dst_addr_q      <= '0;
      src_addr_q      <= '0;
      len_type_q      <= '0;
      fcs_out_q       <= '0;
      frame_bytes_q   <= '0;
      payload_bytes_q <= '0;
      good_cnt_q      <= '0;
      bad_cnt_q       <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      dst_q           <= dst_d;
      src_q           <= src_d;
      len_q           <= len_d;
      fcs_q           <= fcs_d;
      pre_err_q       <= pre_err_d;
      frame_valid_q   <= frame_valid_d;
      frame_error_q   <= frame_error_d;
      err_flags_q     <= err_flags_d;
      dst_addr_q      <= dst_addr_d;
      src_addr_q      <= src_addr_d;
      len_type_q      <= len_type_d;
      fcs_out_q       <= fcs_out_d;
      frame_bytes_q   <= frame_bytes_d;
      payload_bytes_q <= payload_bytes_d;
      good_cnt_q      <= good_cnt_d;
      bad_cnt_q       <= bad_cnt_d;
    end
  end

  assign o_frame_valid   = frame_valid_q;
  assign o_frame_error   = frame_error_q;
  assign o_err_flags     = err_flags_q;
  assign o_dst_addr      = dst_addr_q;
  assign o_src_addr      = src_addr_q;
  assign o_len_type      = len_type_q;
  assign o_fcs           = fcs_out_q;
  assign o_frame_bytes   = frame_bytes_q;
  assign o_payload_bytes = payload_bytes_q;
  assign o_good_cnt      = good_cnt_q;
  assign o_bad_cnt       = bad_cnt_q;

endmodule

// File: tb/tb_mac_checker.sv
// Bench for mac_checker: frames are built as byte lists, serialised onto lanes, and each
// completion is compared with a record derived directly from the byte list.
module tb_mac_checker;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [63:0] i_rx_data;
  logic [7:0]  i_rx_ctrl;
  logic        o_frame_valid, o_frame_error;
  logic [3:0]  o_err_flags;
  logic [47:0] o_dst_addr, o_src_addr;
  logic [15:0] o_len_type;
  logic [31:0] o_fcs;
  logic [15:0] o_frame_bytes, o_payload_bytes, o_good_cnt, o_bad_cnt;

  always #5 clk = ~clk;

  mac_checker dut (
    .clk(clk), .i_rst(i_rst), .i_rx_data(i_rx_data), .i_rx_ctrl(i_rx_ctrl),
    .o_frame_valid(o_frame_valid), .o_frame_error(o_frame_error), .o_err_flags(o_err_flags),
    .o_dst_addr(o_dst_addr), .o_src_addr(o_src_addr), .o_len_type(o_len_type), .o_fcs(o_fcs),
    .o_frame_bytes(o_frame_bytes), .o_payload_bytes(o_payload_bytes),
    .o_good_cnt(o_good_cnt), .o_bad_cnt(o_bad_cnt)
  );

  typedef struct packed {
    logic        v;
    logic        e;
    logic [3:0]  f;
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] lt;
    logic [31:0] fcs;
    logic [15:0] fb;
    logic [15:0] pb;
    logic [15:0] gc;
    logic [15:0] bc;
    logic [15:0] cyc;
  } rec_t;

  logic [7:0] fr[$];
  logic [7:0] lane_d[$];
  logic       lane_c[$];
  rec_t       exp_q[$];
  rec_t       obs_q[$];
  int checks = 0;
  int errors = 0;
  int good_m = 0;
  int bad_m  = 0;

  task automatic set_idle();
    i_rx_data = {8{8'h07}};
    i_rx_ctrl = 8'hFF;
  endtask

  task automatic push_lane(input logic [7:0] d, input logic c);
    lane_d.push_back(d);
    lane_c.push_back(c);
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < 8 * n; i++) push_lane(8'h07, 1'b1);
  endtask

  task automatic make_nominal(input int extra);
    logic [7:0] hdr [14] = '{8'h01, 8'h80, 8'hC2, 8'h00, 8'h00, 8'h01,
                             8'h5A, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h88, 8'h08};
    fr.delete();
    foreach (hdr[i]) fr.push_back(hdr[i]);
    for (int i = 0; i < 46; i++) fr.push_back(8'hAA);
    for (int i = 0; i < 4; i++) fr.push_back(8'hC0);
    for (int i = 0; i < extra; i++) fr.push_back(8'hAA);
  endtask

  task automatic make_random(input int n);
    fr.delete();
    for (int i = 0; i < n; i++) fr.push_back(8'($urandom));
  endtask

  // kind 0: terminate, 1: idle-word abort, 2: cut off by the next start word (length must be a multiple of 8).
  // bad_lane 1..7 corrupts that preamble/SFD lane.
  task automatic add_frame(input int bad_lane, input int kind);
    int n;
    int fb;
    int end_idx;
    logic [7:0] v;
    rec_t r;
    n = fr.size();
    r = '0;
    push_lane(8'hFB, 1'b1);
    for (int j = 1; j < 8; j++) begin
      v = (j == 7) ? 8'hD5 : 8'h55;
      if (j == bad_lane) v = v ^ 8'h01;
      push_lane(v, 1'b0);
    end
    foreach (fr[i]) begin
      push_lane(fr[i], 1'b0);
      if (i < 6)       r.dst[8*(5-i) +: 8]  = fr[i];
      else if (i < 12) r.src[8*(11-i) +: 8] = fr[i];
      else if (i < 14) r.lt[8*(13-i) +: 8]  = fr[i];
    end
    for (int i = (n > 4 ? n - 4 : 0); i < n; i++) r.fcs = {r.fcs[23:0], fr[i]};
    end_idx = lane_d.size();
    if (kind == 0) begin
      push_lane(8'hFD, 1'b1);
      r.f = {1'b0, n > 1518, n < 64, bad_lane != 0};
    end else begin
      if (kind == 1) push_lane(8'h07, 1'b1);
      r.f = {1'b1, 2'b00, bad_lane != 0};
    end
    if (kind != 2) while (lane_d.size() % 8 != 0) push_lane(8'h07, 1'b1);
    fb = (n > 1526) ? 1526 : n;
    r.fb = 16'(fb);
    r.pb = (fb < 18) ? 16'd0 : 16'(fb - 18);
    if (r.f == 4'b0000) good_m++; else bad_m++;
    r.v = (r.f == 4'b0000);
    r.e = (r.f != 4'b0000);
    r.gc = 16'(good_m);
    r.bc = 16'(bad_m);
    r.cyc = 16'(end_idx / 8);
    exp_q.push_back(r);
  endtask

  task automatic play(input int flush);
    int nw;
    rec_t r;
    nw = lane_d.size() / 8;
    obs_q.delete();
    for (int w = 0; w < nw + flush; w++) begin
      if (w < nw) begin
        for (int j = 0; j < 8; j++) begin
          i_rx_data[8*j +: 8] = lane_d[8*w + j];
          i_rx_ctrl[j]        = lane_c[8*w + j];
        end
      end else begin
        set_idle();
      end
      @(posedge clk);
      #1;
      if (o_frame_valid || o_frame_error) begin
        r.v = o_frame_valid; r.e = o_frame_error; r.f = o_err_flags;
        r.dst = o_dst_addr; r.src = o_src_addr; r.lt = o_len_type; r.fcs = o_fcs;
        r.fb = o_frame_bytes; r.pb = o_payload_bytes; r.gc = o_good_cnt; r.bc = o_bad_cnt;
        r.cyc = 16'(w);
        obs_q.push_back(r);
      end
    end
    set_idle();
    lane_d.delete();
    lane_c.delete();
  endtask

  task automatic test_reset();
    checks++;
    if ({o_frame_valid, o_frame_error, o_err_flags} !== 6'b0) begin
      errors++; $display("FAIL reset_pulses got %b want 000000", {o_frame_valid, o_frame_error, o_err_flags});
    end
    checks++;
    if ({o_dst_addr, o_src_addr, o_len_type, o_fcs} !== 144'b0) begin
      errors++; $display("FAIL reset_fields got %h want 0", {o_dst_addr, o_src_addr, o_len_type, o_fcs});
    end
    checks++;
    if ({o_frame_bytes, o_payload_bytes, o_good_cnt, o_bad_cnt} !== 64'b0) begin
      errors++; $display("FAIL reset_counts got %h want 0", {o_frame_bytes, o_payload_bytes, o_good_cnt, o_bad_cnt});
    end
  endtask

  task automatic test_nominal();
    rec_t want;
    add_idle(2);
    make_nominal(0);
    add_frame(0, 0);
    exp_q.delete();
    play(3);
    want = '{v: 1'b1, e: 1'b0, f: 4'h0, dst: 48'h0180C2000001, src: 48'h5A5152535455,
             lt: 16'h8808, fcs: 32'hC0C0C0C0, fb: 16'd64, pb: 16'd46, gc: 16'd1, bc: 16'd0,
             cyc: 16'd11};
    checks++;
    if (obs_q.size() != 1) begin
      errors++; $display("FAIL nominal_pulses got %0d want 1", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0] !== want) begin
        errors++; $display("FAIL nominal_record got %h want %h", obs_q[0], want);
      end
    end
  endtask

  task automatic test_term_midword();
    make_nominal(3);
    add_frame(0, 0);
    play(2);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL midword_pulses got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= obs_q.size()) begin errors++; $display("FAIL midword_rec%0d got none want %h", i, exp_q[i]); end
      else if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL midword_rec%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    exp_q.delete();
  endtask

  task automatic test_runt();
    make_random(40);
    add_frame(0, 0);
    play(3);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL runt_pulses got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= obs_q.size()) begin errors++; $display("FAIL runt_rec%0d got none want %h", i, exp_q[i]); end
      else if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL runt_rec%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    exp_q.delete();
    checks++;
    if ({o_frame_valid, o_frame_error, o_err_flags} !== 6'b000010) begin
      errors++; $display("FAIL runt_flags_held got %b want 000010", {o_frame_valid, o_frame_error, o_err_flags});
    end
  endtask

  task automatic test_bad_sfd();
    make_nominal(0);
    add_frame(7, 0);
    add_idle(1);
    make_nominal(0);
    add_frame(0, 0);
    play(2);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL bad_sfd_pulses got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= obs_q.size()) begin errors++; $display("FAIL bad_sfd_rec%0d got none want %h", i, exp_q[i]); end
      else if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL bad_sfd_rec%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    exp_q.delete();
  endtask

  task automatic test_abort();
    make_random(16);
    add_frame(0, 1);
    add_idle(1);
    make_random(24);
    add_frame(0, 2);
    make_nominal(0);
    add_frame(0, 0);
    play(2);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL abort_pulses got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= obs_q.size()) begin errors++; $display("FAIL abort_rec%0d got none want %h", i, exp_q[i]); end
      else if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL abort_rec%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      make_random($urandom_range(64, 100));
      add_frame(0, 0);
    end
    play(2);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL b2b_pulses got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= obs_q.size()) begin errors++; $display("FAIL b2b_rec%0d got none want %h", i, exp_q[i]); end
      else if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_rec%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    exp_q.delete();
  endtask

  task automatic test_random();
    int n, sel, kind, bad, prev_kind;
    prev_kind = 0;
    for (int k = 0; k < 40; k++) begin
      if (prev_kind != 2) add_idle($urandom_range(0, 2));
      sel = $urandom_range(0, 9);
      if (sel == 0)     n = $urandom_range(1500, 1600);
      else if (sel < 3) n = $urandom_range(0, 63);
      else              n = $urandom_range(64, 300);
      sel = $urandom_range(0, 9);
      kind = (sel == 0) ? 1 : ((sel == 1 && k != 39) ? 2 : 0);
      if (kind == 2) n = n - (n % 8);
      bad = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 7) : 0;
      make_random(n);
      add_frame(bad, kind);
      prev_kind = kind;
    end
    play(2);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL random_pulses got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= obs_q.size()) begin errors++; $display("FAIL random_rec%0d got none want %h", i, exp_q[i]); end
      else if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL random_rec%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    exp_q.delete();
  endtask

  task automatic test_mid_reset();
    int pulses;
    pulses = 0;
    make_nominal(0);
    add_frame(0, 0);
    exp_q.delete();
    for (int w = 0; w < 4; w++) begin
      for (int j = 0; j < 8; j++) begin
        i_rx_data[8*j +: 8] = lane_d[8*w + j];
        i_rx_ctrl[j]        = lane_c[8*w + j];
      end
      @(posedge clk);
      #1;
      if (o_frame_valid || o_frame_error) pulses++;
    end
    lane_d.delete();
    lane_c.delete();
    #3;
    i_rst = 1'b1;
    #1;
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL midrst_pulse_before got %0d want 0", pulses);
    end
    checks++;
    if ({o_frame_valid, o_frame_error, o_err_flags, o_dst_addr, o_src_addr, o_len_type, o_fcs,
         o_frame_bytes, o_payload_bytes, o_good_cnt, o_bad_cnt} !== 214'b0) begin
      errors++; $display("FAIL midrst_outputs got cnt %h/%h bytes %h want all 0", o_good_cnt, o_bad_cnt, o_frame_bytes);
    end
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    i_rst = 1'b0;
    good_m = 0;
    bad_m = 0;
    make_nominal(0);
    add_frame(0, 0);
    play(2);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL midrst_pulses got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= obs_q.size()) begin errors++; $display("FAIL midrst_rec%0d got none want %h", i, exp_q[i]); end
      else if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL midrst_rec%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    exp_q.delete();
  endtask

  initial begin
    i_rst = 1'b1;
    set_idle();
    repeat (3) @(posedge clk);
    #1;
    i_rst = 1'b0;
    test_reset();
    test_nominal();
    test_term_midword();
    test_runt();
    test_bad_sfd();
    test_abort();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
